// File: rtl/wrlvl_pkg.sv
// Shared definitions for the write-levelling lane: state encoding, tap width
// and default parameter values.
package wrlvl_pkg;

  localparam int TAP_W             = 8;
  localparam int VOTE_W            = 4;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_FB_SAMPLES    = 4;
  localparam int DEF_MAX_TAPS      = 128;
  localparam int DEF_FB_TIMEOUT    = 64;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_SETTLE  = 4'd2,
    ST_PULSE   = 4'd3,
    ST_WAIT_FB = 4'd4,
    ST_EVAL    = 4'd5,
    ST_STEP    = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERROR   = 4'd8
  } wrlvl_state_t;

  // States in which an out-of-range delay line aborts the search.
  function automatic logic is_active(input wrlvl_state_t s);
    return s inside {ST_LOAD, ST_SETTLE, ST_PULSE, ST_WAIT_FB, ST_EVAL, ST_STEP};
  endfunction

endpackage

// File: rtl/wrlvl_fb_vote.sv
// Feedback accumulator: counts samples and ones at one tap position and
// reports a strict-majority vote (a tie reads as 0).
module wrlvl_fb_vote
  import wrlvl_pkg::*;
#(
  parameter int FB_SAMPLES = DEF_FB_SAMPLES
) (
  input  logic SCLK,
  input  logic reset,
  input  logic clr,
  input  logic sample_en,
  input  logic sample_bit,
  output logic last_sample,
  output logic vote
);

  logic [VOTE_W-1:0] sample_cnt_reg;
  logic [VOTE_W-1:0] ones_cnt_reg;

  always_ff @(posedge SCLK) begin
    if (reset || clr) begin
      sample_cnt_reg <= '0;
      ones_cnt_reg   <= '0;
    end else if (sample_en) begin
      sample_cnt_reg <= sample_cnt_reg + VOTE_W'(1);
      ones_cnt_reg   <= ones_cnt_reg + VOTE_W'(sample_bit);
    end
  end

  // True while the sample being taken is the final one for this tap.
  assign last_sample = (sample_cnt_reg == VOTE_W'(FB_SAMPLES - 1));
  assign vote        = ({ones_cnt_reg, 1'b0} > (VOTE_W + 1)'(FB_SAMPLES));

endmodule

// File: rtl/wrlvl_lane.sv
// Write-levelling search for one byte lane: sweeps the tx delay line upward
// until feedback goes 0 -> 1. Optional feedback timeout via WRLVL_TIMEOUT_EN.
module wrlvl_lane
  import wrlvl_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int FB_SAMPLES    = DEF_FB_SAMPLES,
  parameter int MAX_TAPS      = DEF_MAX_TAPS,
  parameter int FB_TIMEOUT    = DEF_FB_TIMEOUT
) (
  input  logic             SCLK,
  input  logic             reset,
  input  logic             dfi_wrlvl_en,
  output logic             wrlvl_dqs_pulse,
  input  logic             wrlvl_fb_valid,
  input  logic             wrlvl_fb_dq,
  output logic             txdelay_load,
  output logic             txdelay_move,
  output logic             txdelay_direction,
  input  logic             txdelay_oor,
  output logic             dfi_wrlvl_resp,
  output logic             wr_training_error,
  output logic [TAP_W-1:0] wrlvl_tap
);

  localparam int               SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(MAX_TAPS - 1);

`ifdef WRLVL_TIMEOUT_EN
  localparam int                    FB_WAIT_W    = $clog2(FB_TIMEOUT + 1);
  localparam logic [FB_WAIT_W-1:0]  FB_WAIT_LAST = FB_WAIT_W'(FB_TIMEOUT - 1);
  logic [FB_WAIT_W-1:0] fb_wait_reg;
`endif

  wrlvl_state_t         state_reg;
  logic [SETTLE_W-1:0]  settle_cnt_reg;
  logic                 seen_zero_reg;
  logic                 vote_clr;
  logic                 vote_sample;
  logic                 last_sample;
  logic                 vote;

  assign vote_clr    = (state_reg == ST_LOAD) || (state_reg == ST_STEP);
  assign vote_sample = (state_reg == ST_WAIT_FB) && wrlvl_fb_valid;

  wrlvl_fb_vote #(
    .FB_SAMPLES (FB_SAMPLES)
  ) u_fb_vote (
    .SCLK        (SCLK),
    .reset       (reset),
    .clr         (vote_clr),
    .sample_en   (vote_sample),
    .sample_bit  (wrlvl_fb_dq),
    .last_sample (last_sample),
    .vote        (vote)
  );

  // Outputs are registered alongside the state they belong to, so each pulse
  // is high exactly for the cycle its state is resident.
  always_ff @(posedge SCLK) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      settle_cnt_reg    <= '0;
      seen_zero_reg     <= 1'b0;
      wrlvl_tap         <= '0;
      wrlvl_dqs_pulse   <= 1'b0;
      txdelay_load      <= 1'b0;
      txdelay_move      <= 1'b0;
      txdelay_direction <= 1'b0;
      dfi_wrlvl_resp    <= 1'b0;
      wr_training_error <= 1'b0;
`ifdef WRLVL_TIMEOUT_EN
      fb_wait_reg       <= '0;
`endif
    end else begin
      wrlvl_dqs_pulse   <= 1'b0;
      txdelay_load      <= 1'b0;
      txdelay_move      <= 1'b0;
      txdelay_direction <= 1'b0;

      if (!dfi_wrlvl_en) begin
        state_reg         <= ST_IDLE;
        dfi_wrlvl_resp    <= 1'b0;
        wr_training_error <= 1'b0;
      end else if (txdelay_oor && is_active(state_reg)) begin
        state_reg         <= ST_ERROR;
        dfi_wrlvl_resp    <= 1'b1;
        wr_training_error <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_reg     <= ST_LOAD;
            txdelay_load  <= 1'b1;
            wrlvl_tap     <= '0;
            seen_zero_reg <= 1'b0;
          end

          ST_LOAD: begin
            state_reg      <= ST_SETTLE;
            settle_cnt_reg <= '0;
          end

          ST_SETTLE: begin
            if (settle_cnt_reg == SETTLE_LAST) begin
              state_reg       <= ST_PULSE;
              wrlvl_dqs_pulse <= 1'b1;
            end else begin
              settle_cnt_reg <= settle_cnt_reg + SETTLE_W'(1);
            end
          end

          ST_PULSE: begin
            state_reg <= ST_WAIT_FB;
`ifdef WRLVL_TIMEOUT_EN
            // The strobe cycle itself counts toward the timeout window.
            fb_wait_reg <= FB_WAIT_W'(1);
`endif
          end

          ST_WAIT_FB: begin
            if (wrlvl_fb_valid) begin
              if (last_sample) begin
                state_reg <= ST_EVAL;
              end else begin
                state_reg       <= ST_PULSE;
                wrlvl_dqs_pulse <= 1'b1;
              end
            end
`ifdef WRLVL_TIMEOUT_EN
            else if (fb_wait_reg == FB_WAIT_LAST) begin
              state_reg         <= ST_ERROR;
              dfi_wrlvl_resp    <= 1'b1;
              wr_training_error <= 1'b1;
            end else begin
              fb_wait_reg <= fb_wait_reg + FB_WAIT_W'(1);
            end
`else
            else begin
              state_reg <= ST_WAIT_FB;
            end
`endif
          end

          ST_EVAL: begin
            if (vote && seen_zero_reg) begin
              state_reg         <= ST_DONE;
              dfi_wrlvl_resp    <= 1'b1;
              wr_training_error <= 1'b0;
            end else begin
              if (!vote) begin
                seen_zero_reg <= 1'b1;
              end
              // Stepping past the last tap would wrap the counter; fail instead.
              if (wrlvl_tap == TAP_LAST) begin
                state_reg         <= ST_ERROR;
                dfi_wrlvl_resp    <= 1'b1;
                wr_training_error <= 1'b1;
              end else begin
                state_reg         <= ST_STEP;
                txdelay_move      <= 1'b1;
                txdelay_direction <= 1'b1;
              end
            end
          end

          ST_STEP: begin
            state_reg      <= ST_SETTLE;
            settle_cnt_reg <= '0;
            wrlvl_tap      <= wrlvl_tap + TAP_W'(1);
          end

          ST_DONE, ST_ERROR: begin
            state_reg <= state_reg;
          end

          default: begin
            state_reg         <= ST_IDLE;
            dfi_wrlvl_resp    <= 1'b0;
            wr_training_error <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wrlvl_lane.sv
// Scoreboard bench for wrlvl_lane: a DRAM feedback model answers each strobe,
// expected levelling results are queued and checked when the response rises.
`timescale 1ns/1ps
module tb_wrlvl_lane;

  logic       SCLK;
  logic       reset;
  logic       dfi_wrlvl_en;
  logic       wrlvl_dqs_pulse;
  logic       wrlvl_fb_valid;
  logic       wrlvl_fb_dq;
  logic       txdelay_load;
  logic       txdelay_move;
  logic       txdelay_direction;
  logic       txdelay_oor;
  logic       dfi_wrlvl_resp;
  logic       wr_training_error;
  logic [7:0] wrlvl_tap;

  wrlvl_lane #(
    .SETTLE_CYCLES (8),
    .FB_SAMPLES    (4),
    .MAX_TAPS      (128),
    .FB_TIMEOUT    (64)
  ) dut (
    .SCLK              (SCLK),
    .reset             (reset),
    .dfi_wrlvl_en      (dfi_wrlvl_en),
    .wrlvl_dqs_pulse   (wrlvl_dqs_pulse),
    .wrlvl_fb_valid    (wrlvl_fb_valid),
    .wrlvl_fb_dq       (wrlvl_fb_dq),
    .txdelay_load      (txdelay_load),
    .txdelay_move      (txdelay_move),
    .txdelay_direction (txdelay_direction),
    .txdelay_oor       (txdelay_oor),
    .dfi_wrlvl_resp    (dfi_wrlvl_resp),
    .wr_training_error (wr_training_error),
    .wrlvl_tap         (wrlvl_tap)
  );

  typedef struct {
    int err;
    int tap;
    int moves;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   move_cnt = 0;     // model delay-line position
  int   resp_seen = 0;
  int   fb_mode = 0;      // 0: always 0, 1: 1/0/1 band, 2: marginal votes
  bit   fb_on = 1'b1;
  int   fb_delay = 0;
  int   sample_idx = 0;
  int   idx_tap = -1;

  initial begin
    SCLK = 1'b0;
    forever #5 SCLK = ~SCLK;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  function automatic bit fb_fn(input int mode, input int tap, input int idx);
    case (mode)
      1: return (tap <= 5) || (tap >= 20);
      2: begin
        if (tap == 10) return idx < 2;
        if (tap == 11) return idx < 3;
        return tap >= 12;
      end
      default: return 1'b0;
    endcase
  endfunction

  // DRAM feedback model: answers each strobe two cycles later.
  always begin
    @(posedge SCLK);
    #1;
    wrlvl_fb_valid = 1'b0;
    if (txdelay_load) sample_idx = 0;
    if (fb_delay != 0) begin
      fb_delay--;
      if (fb_delay == 0) wrlvl_fb_valid = 1'b1;
    end
    if (wrlvl_dqs_pulse && fb_on) begin
      if (move_cnt != idx_tap) begin
        idx_tap    = move_cnt;
        sample_idx = 0;
      end
      wrlvl_fb_dq = fb_fn(fb_mode, move_cnt, sample_idx);
      sample_idx++;
      fb_delay = 2;
    end
  end

  // Monitor: tracks the delay line and scores each completed levelling run.
  always begin
    bit   prev_resp;
    exp_t e;
    @(negedge SCLK);
    if (reset) begin
      move_cnt  = 0;
      prev_resp = 1'b0;
    end else begin
      if (txdelay_load) move_cnt = 0;
      if (txdelay_move) begin
        move_cnt++;
        check("move_direction", int'(txdelay_direction), 1);
      end
      if (dfi_wrlvl_resp && !prev_resp) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_error", int'(wr_training_error), e.err);
          check("resp_tap", int'(wrlvl_tap), e.tap);
          check("resp_moves", move_cnt, e.moves);
        end
        resp_seen++;
      end
      prev_resp = dfi_wrlvl_resp;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge SCLK);
    #1;
  endtask

  task automatic wait_resp(input int target, input string name);
    int n = 0;
    while (resp_seen < target && n < 20000) begin
      @(posedge SCLK);
      n++;
    end
    #1;
    if (resp_seen < target) check({name, "_timeout"}, resp_seen, target);
  endtask

  task automatic wait_moves(input int target, input string name);
    int n = 0;
    while (move_cnt != target && n < 20000) begin
      @(posedge SCLK);
      n++;
    end
    if (move_cnt != target) check({name, "_timeout"}, move_cnt, target);
  endtask

  initial begin
    int n;
    int pulses;
    exp_t e;
    reset        = 1'b1;
    dfi_wrlvl_en = 1'b1;   // reset must win over enable
    txdelay_oor  = 1'b0;
    wrlvl_fb_valid = 1'b0;
    wrlvl_fb_dq  = 1'b0;
    tick(3);
    check("rst_load", int'(txdelay_load), 0);
    check("rst_move", int'(txdelay_move), 0);
    check("rst_dqs", int'(wrlvl_dqs_pulse), 0);
    check("rst_resp", int'(dfi_wrlvl_resp), 0);
    check("rst_err", int'(wr_training_error), 0);
    check("rst_tap", int'(wrlvl_tap), 0);
    check("rst_dir", int'(txdelay_direction), 0);
    dfi_wrlvl_en = 1'b0;
    reset = 1'b0;
    tick(3);

    // Feedback 1 for taps 0-5, 0 for 6-19, 1 from 20: pass at tap 20.
    fb_mode = 1;
    e = '{err: 0, tap: 20, moves: 20};
    exp_q.push_back(e);
    dfi_wrlvl_en = 1'b1;
    wait_resp(1, "band");
    tick(3);
    check("band_resp_held", int'(dfi_wrlvl_resp), 1);
    reset = 1'b1;
    tick(1);
    check("midrst_tap", int'(wrlvl_tap), 0);
    check("midrst_resp", int'(dfi_wrlvl_resp), 0);
    reset = 1'b0;
    dfi_wrlvl_en = 1'b0;
    tick(3);

    // Feedback always 0: fail at the last tap.
    fb_mode = 0;
    e = '{err: 1, tap: 127, moves: 127};
    exp_q.push_back(e);
    dfi_wrlvl_en = 1'b1;
    wait_resp(2, "allzero");
    dfi_wrlvl_en = 1'b0;
    tick(1);
    check("drop_resp", int'(dfi_wrlvl_resp), 0);
    check("drop_err", int'(wr_training_error), 0);
    check("drop_tap_held", int'(wrlvl_tap), 127);
    tick(2);

    // 2/4 at tap 10 is a tie (0), 3/4 at tap 11 passes.
    fb_mode = 2;
    e = '{err: 0, tap: 11, moves: 11};
    exp_q.push_back(e);
    dfi_wrlvl_en = 1'b1;
    wait_resp(3, "vote");
    dfi_wrlvl_en = 1'b0;
    tick(3);

    // Delay line reports out of range at tap 30.
    fb_mode = 0;
    e = '{err: 1, tap: 30, moves: 30};
    exp_q.push_back(e);
    dfi_wrlvl_en = 1'b1;
    wait_moves(30, "oor");
    #1;
    txdelay_oor = 1'b1;
    tick(1);
    check("oor_resp", int'(dfi_wrlvl_resp), 1);
    check("oor_err", int'(wr_training_error), 1);
    txdelay_oor = 1'b0;
    tick(40);
    check("oor_no_more_moves", move_cnt, 30);
    wait_resp(4, "oor");
    dfi_wrlvl_en = 1'b0;
    tick(3);

    // Enable dropped during SETTLE at tap 7, then restarted.
    e = '{err: 0, tap: 0, moves: 0};
    dfi_wrlvl_en = 1'b1;
    wait_moves(7, "abort");
    #1;
    dfi_wrlvl_en = 1'b0;
    tick(1);
    check("abort_tap", int'(wrlvl_tap), 7);
    check("abort_dqs", int'(wrlvl_dqs_pulse), 0);
    check("abort_resp", int'(dfi_wrlvl_resp), 0);
    tick(5);
    check("abort_tap_held", int'(wrlvl_tap), 7);
    dfi_wrlvl_en = 1'b1;
    tick(1);
    check("restart_load", int'(txdelay_load), 1);
    tick(1);
    check("restart_load_end", int'(txdelay_load), 0);
    check("restart_tap", int'(wrlvl_tap), 0);
    dfi_wrlvl_en = 1'b0;
    tick(3);

    // No feedback at all.
    fb_on = 1'b0;
`ifdef WRLVL_TIMEOUT_EN
    e = '{err: 1, tap: 0, moves: 0};
    exp_q.push_back(e);
`endif
    dfi_wrlvl_en = 1'b1;
    n = 0;
    while (!wrlvl_dqs_pulse && n < 100) begin
      tick(1);
      n++;
    end
    check("nofb_first_pulse", int'(wrlvl_dqs_pulse), 1);
`ifdef WRLVL_TIMEOUT_EN
    n = 0;
    while (!dfi_wrlvl_resp && n < 200) begin
      tick(1);
      n++;
    end
    check("timeout_cycles", n, 64);
    check("timeout_err", int'(wr_training_error), 1);
    wait_resp(5, "timeout");
`else
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (wrlvl_dqs_pulse) pulses++;
    end
    check("nofb_extra_pulses", pulses, 0);
    check("nofb_resp", int'(dfi_wrlvl_resp), 0);
`endif
    dfi_wrlvl_en = 1'b0;
    tick(3);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
